// File: rtl/exe_stage_pkg.sv
// arm_exe_pkg: ALU command codes, shift types, NZCV bit indices and
// small helpers shared by the ARM execute stage.
package arm_exe_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [31:0] ror32(
        input logic [31:0] x,
        input logic [4:0]  amt
    );
        logic [63:0] t;
        t = {x, x} >> amt;
        return t[31:0];
    endfunction

    function automatic logic add_ovf(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] r
    );
        return (a[31] == b[31]) && (r[31] != a[31]);
    endfunction

    function automatic logic sub_ovf(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] r
    );
        return (a[31] != b[31]) && (r[31] != a[31]);
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// exe_stage_if: ID/EX operand bundle into the execute stage and the
// EX/MEM, branch and NZCV results out of it (fwd ports with EXE_FWD_EN).
interface exe_stage_if;

    logic        S_UpdateSig;
    logic        branch;
    logic        memReadEn;
    logic        memWriteEn;
    logic        writeBackEn;
    logic [3:0]  exeCMD;
    logic [31:0] res1;
    logic [31:0] res2;
    logic [31:0] PC;
    logic [23:0] signedImm24;
    logic [3:0]  R_d;
    logic        isImmidiate;
    logic [11:0] shiftOperand;
`ifdef EXE_FWD_EN
    logic [1:0]  sel_src1;
    logic [1:0]  sel_src2;
    logic [31:0] memFwdVal;
    logic [31:0] wbFwdVal;
`endif
    logic [3:0]  status;
    logic        branchTaken;
    logic [31:0] branchAddr;
    logic [31:0] aluResOut;
    logic [31:0] valRmOut;
    logic [3:0]  R_dOut;
    logic        writeBackEnOut;
    logic        memReadEnOut;
    logic        memWriteEnOut;

    modport master (
        output S_UpdateSig, branch, memReadEn, memWriteEn,
        output writeBackEn, exeCMD, res1, res2, PC,
        output signedImm24, R_d, isImmidiate, shiftOperand,
        input  status, branchTaken, branchAddr, aluResOut,
        input  valRmOut, R_dOut, writeBackEnOut,
        input  memReadEnOut, memWriteEnOut
`ifdef EXE_FWD_EN
        , output sel_src1, sel_src2, memFwdVal, wbFwdVal
`endif
    );

    modport slave (
        input  S_UpdateSig, branch, memReadEn, memWriteEn,
        input  writeBackEn, exeCMD, res1, res2, PC,
        input  signedImm24, R_d, isImmidiate, shiftOperand,
        output status, branchTaken, branchAddr, aluResOut,
        output valRmOut, R_dOut, writeBackEnOut,
        output memReadEnOut, memWriteEnOut
`ifdef EXE_FWD_EN
        , input sel_src1, sel_src2, memFwdVal, wbFwdVal
`endif
    );

endinterface

// File: rtl/exe_stage_val2_gen.sv
// val2_gen: combinational second-operand generator (memory offset,
// rotated immediate or shifted Rm).
module val2_gen
    import arm_exe_pkg::*;
(
    input  logic [31:0] rm,
    input  logic [11:0] shift_operand,
    input  logic        is_imm,
    input  logic        mem_op,
    output logic [31:0] val2
);

    logic [4:0] rot;
    logic [4:0] amt;

    assign rot = {shift_operand[11:8], 1'b0};
    assign amt = shift_operand[11:7];

    always_comb begin
        val2 = rm;
        if (mem_op) begin
            val2 = {20'b0, shift_operand};
        end else if (is_imm) begin
            val2 = ror32({24'b0, shift_operand[7:0]}, rot);
        end else begin
            case (shift_operand[6:5])
                SH_LSL: val2 = rm << amt;
                SH_LSR: val2 = rm >> amt;
                SH_ASR: val2 = $unsigned($signed(rm) >>> amt);
                SH_ROR: val2 = ror32(rm, amt);
                default: val2 = rm;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// exe_stage: ARM execute stage - Val2, ALU, NZCV and EX/MEM registers.
// Define EXE_FWD_EN to add operand forwarding from MEM and WB.
module exe_stage
    import arm_exe_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       freeze,
    exe_stage_if.slave bus
);

    logic [DW-1:0] src1;
    logic [DW-1:0] src2;
    logic [31:0]   val2;
    logic [31:0]   res;
    logic [32:0]   sum;
    logic          c;
    logic          v;
    logic [3:0]    nzcv;

`ifdef EXE_FWD_EN
    always_comb begin
        case (bus.sel_src1)
            2'b01:   src1 = bus.memFwdVal;
            2'b10:   src1 = bus.wbFwdVal;
            default: src1 = bus.res1;
        endcase
        case (bus.sel_src2)
            2'b01:   src2 = bus.memFwdVal;
            2'b10:   src2 = bus.wbFwdVal;
            default: src2 = bus.res2;
        endcase
    end
`else
    assign src1 = bus.res1;
    assign src2 = bus.res2;
`endif

    val2_gen u_val2 (
        .rm            (src2),
        .shift_operand (bus.shiftOperand),
        .is_imm        (bus.isImmidiate),
        .mem_op        (bus.memReadEn | bus.memWriteEn),
        .val2          (val2)
    );

    // carry-in for ADC/SBC is the flag value before this op updates it
    always_comb begin
        sum = '0;
        res = '0;
        c   = bus.status[FLAG_C];
        v   = bus.status[FLAG_V];
        case (bus.exeCMD)
            CMD_MOV: res = val2;
            CMD_MVN: res = ~val2;
            CMD_AND: res = src1 & val2;
            CMD_ORR: res = src1 | val2;
            CMD_EOR: res = src1 ^ val2;
            CMD_ADD, CMD_ADC: begin
                sum = {1'b0, src1} + {1'b0, val2}
                    + {32'b0, (bus.exeCMD == CMD_ADC)
                              & bus.status[FLAG_C]};
                res = sum[31:0];
                c   = sum[32];
                v   = add_ovf(src1, val2, res);
            end
            CMD_SUB, CMD_SBC: begin
                sum = {1'b0, src1} - {1'b0, val2}
                    - {32'b0, (bus.exeCMD == CMD_SBC)
                              & ~bus.status[FLAG_C]};
                res = sum[31:0];
                c   = ~sum[32];
                v   = sub_ovf(src1, val2, res);
            end
            default: res = '0;
        endcase
    end

    assign nzcv = {res[31], res == 32'b0, c, v};

    assign bus.branchTaken = bus.branch;
    assign bus.branchAddr  = bus.PC
        + {{6{bus.signedImm24[23]}}, bus.signedImm24, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.aluResOut      <= '0;
            bus.valRmOut       <= '0;
            bus.R_dOut         <= '0;
            bus.writeBackEnOut <= 1'b0;
            bus.memReadEnOut   <= 1'b0;
            bus.memWriteEnOut  <= 1'b0;
            bus.status         <= '0;
        end else if (!freeze) begin
            bus.aluResOut      <= res;
            bus.valRmOut       <= src2;
            bus.R_dOut         <= bus.R_d;
            bus.writeBackEnOut <= bus.writeBackEn;
            bus.memReadEnOut   <= bus.memReadEn;
            bus.memWriteEnOut  <= bus.memWriteEn;
            if (bus.S_UpdateSig)
                bus.status <= nzcv;
        end
    end

endmodule
